refresh_scheduler: RTL and testbench
====================================

# refresh_scheduler

Sequences per-row refresh for the DRAM controller by driving the WUPR row-tracking unit. A tREFI timer accrues refresh credits; for each credit the scheduler queries WUPR for the current sweep row. Rows WUPR reports as needing refresh become a request to the command arbiter; all other rows are skipped. It sits between WUPR and the command scheduler and owns the row sweep pointer.

## Interface
- ROW_WIDTH, 16, row address width; sweep covers 0 to 2^ROW_WIDTH-1.
- TREFI, 780, cycles between refresh credits (≥ 8).
- TRFC, 26, cycles the scheduler stays busy after a grant (≥ 1).
- MAX_POSTPONE, 8, credit counter saturation value (≥ 2).

Clocking and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wupr_to_refresh  out  1  one-cycle query strobe to WUPR.
- wupr_ra  out  ROW_WIDTH  row under query; equals row_ptr in all cycles.
- wupr_clk_enable  out  1  WUPR clock enable; high in QUERY and WAIT only.
- wupr_dref  in  1  WUPR verdict, valid in the cycle after the strobe; 1 means refresh is needed.
- ref_req  out  1  refresh request to the command arbiter.
- ref_row  out  ROW_WIDTH  row to refresh; stable while ref_req is high.
- ref_grant  in  1  arbiter accept; counts only when ref_req is high.
- ref_urgent  out  1  high when pending == MAX_POSTPONE.
- sweep_done  out  1  one-cycle pulse when row_ptr wraps to 0.
- skip_cnt  out  16  saturating count of skipped rows.
- issued_cnt  out  16  saturating count of granted refreshes.

## Operation
- **Timer:** tmr loads TREFI-1 on reset and decrements every cycle. In the cycle where tmr == 0 it reloads TREFI-1 and raises `tick`.
- **Credit counter:** pending has width $clog2(MAX_POSTPONE+1).
  - `tick` increments pending, saturating at MAX_POSTPONE. A tick at saturation is dropped.
  - A retire (skip or end of BUSY) decrements pending.
  - Tick and retire in the same cycle leave pending unchanged.
- **FSM states:** IDLE, QUERY, WAIT, REQ, BUSY.
  - IDLE: go to QUERY when pending != 0.
  - QUERY (1 cycle): wupr_to_refresh=1 and wupr_clk_enable=1. Go to WAIT.
  - WAIT (1 cycle): wupr_clk_enable=1; sample wupr_dref.
    - If dref=1, go to REQ.
    - If dref=0, skip the row: retire, advance row_ptr, increment skip_cnt, go to IDLE.
  - REQ: ref_req=1 and ref_row=row_ptr. Hold until ref_grant; the request is never withdrawn.
    - Grant in the same cycle: go to BUSY and load busy_cnt with TRFC-1.
  - BUSY: decrement busy_cnt.
    - When busy_cnt == 0: retire, advance row_ptr, increment issued_cnt, go to IDLE.
- **Row pointer:** row_ptr advances modulo 2^ROW_WIDTH. sweep_done pulses in the cycle after the advance from all-ones to 0.
- **Status counters:** skip_cnt and issued_cnt saturate at 16'hFFFF.
- **ref_grant outside REQ** is ignored.
- **Timer while busy:** the timer keeps running in every state. Credits accrue during REQ and BUSY.

## Timing
- **Reset values:** all outputs 0, row_ptr=0, pending=0, state IDLE, tmr=TREFI-1.
- **Reset mid-operation:** rst sampled high clears everything by the next cycle, including an active ref_req, with no completion of a pending request.
- **Cycle numbering:** cycle 0 is the first cycle with rst low.
  - First tick at cycle TREFI-1; pending=1 from cycle TREFI.
  - QUERY at cycle TREFI+1, WAIT at TREFI+2.
  - REQ or skip takes effect from TREFI+3.
- **Credit-to-query latency:** 2 cycles from tick to wupr_to_refresh.
- **Skip turnaround:** 3 cycles (IDLE→QUERY→WAIT→IDLE).
- **Back-to-back queries:** with pending ≥ 2, the next query comes 3 cycles after a skip, or 1 cycle after BUSY exits.
- **Grant to retire:** grant in cycle G puts BUSY in cycles G+1 to G+TRFC; pending decrements visibly at G+TRFC+1.
- **ref_urgent** is combinational from the registered pending value.

## Test plan
Bench parameters: TREFI=20, TRFC=4, MAX_POSTPONE=4, ROW_WIDTH=4.
- **Reset values:** hold rst 3 cycles, then release → all outputs 0; first wupr_to_refresh at cycle 21 with wupr_ra=0.
- **Skip path:** wupr_dref=0 always → one query every 20 cycles, ref_req never high, skip_cnt=5 after 5 ticks, wupr_ra steps 0,1,2,3,4.
- **Refresh path:** wupr_dref=1, ref_grant tied 1 → ref_req high for exactly 1 cycle with ref_row=0, then 4 BUSY cycles, then issued_cnt=1 and row_ptr=1.
- **Postpone saturation:** wupr_dref=1, ref_grant=0 for 120 cycles.
  - ref_urgent rises once pending reaches 4 and further ticks are dropped.
  - Then grant continuously → exactly 4 refreshes, rows 0 to 3, then pending=0.
- **Sweep wrap:** wupr_dref=0 for 16 credits → sweep_done pulses once, after row 15; the next wupr_ra is 0.
- **Reset during REQ:** assert rst while ref_req=1 → ref_req=0 next cycle, pending=0, row_ptr=0; the timer restarts at TREFI-1.

Source files
------------

// File: rtl/refresh_scheduler.sv
// Per-row refresh sequencer: a tREFI timer accrues credits, each credit queries
// WUPR for the current sweep row and either skips it or requests a refresh.
module refresh_scheduler #(
   parameter int ROW_WIDTH    = 16,
   parameter int TREFI        = 780,
   parameter int TRFC         = 26,
   parameter int MAX_POSTPONE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 wupr_to_refresh,
   output logic [ROW_WIDTH-1:0] wupr_ra,
   output logic                 wupr_clk_enable,
   input  logic                 wupr_dref,
   output logic                 ref_req,
   output logic [ROW_WIDTH-1:0] ref_row,
   input  logic                 ref_grant,
   output logic                 ref_urgent,
   output logic                 sweep_done,
   output logic [15:0]          skip_cnt,
   output logic [15:0]          issued_cnt
);

   localparam int TMR_W  = $clog2(TREFI);
   localparam int PEND_W = $clog2(MAX_POSTPONE + 1);
   localparam int BUSY_W = (TRFC > 1) ? $clog2(TRFC) : 1;

   localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(TREFI - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_POSTPONE);
   localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(TRFC - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_QUERY = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_REQ   = 3'd3;
   localparam logic [2:0] S_BUSY  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [PEND_W-1:0]    pend_q, pend_d;
   logic [BUSY_W-1:0]    busy_q, busy_d;
   logic [ROW_WIDTH-1:0] row_q, row_d;
   logic [15:0]          skip_q, skip_d;
   logic [15:0]          issued_q, issued_d;
   logic                 sweep_q, sweep_d;

   logic tick;
   logic retire;
   logic advance;
   logic skip_inc;
   logic issue_inc;

   always_comb begin
      tick      = (tmr_q == '0);
      tmr_d     = tick ? TMR_RELOAD : tmr_q - TMR_W'(1);
      state_d   = state_q;
      busy_d    = busy_q;
      retire    = 1'b0;
      advance   = 1'b0;
      skip_inc  = 1'b0;
      issue_inc = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pend_q != '0) state_d = S_QUERY;
         end
         S_QUERY: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wupr_dref) begin
               state_d = S_REQ;
            end else begin
               retire   = 1'b1;
               advance  = 1'b1;
               skip_inc = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_REQ: begin
            // The request is held until accepted; it is never withdrawn.
            if (ref_grant) begin
               state_d = S_BUSY;
               busy_d  = BUSY_LOAD;
            end
         end
         S_BUSY: begin
            if (busy_q == '0) begin
               retire    = 1'b1;
               advance   = 1'b1;
               issue_inc = 1'b1;
               state_d   = S_IDLE;
            end else begin
               busy_d = busy_q - BUSY_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A tick and a retire in the same cycle cancel; a tick at saturation is lost.
      pend_d = pend_q;
      if (tick && !retire && (pend_q != PEND_MAX)) begin
         pend_d = pend_q + PEND_W'(1);
      end else if (retire && !tick) begin
         pend_d = pend_q - PEND_W'(1);
      end

      row_d    = advance ? row_q + ROW_WIDTH'(1) : row_q;
      sweep_d  = advance && (row_q == '1);
      skip_d   = (skip_inc && (skip_q != 16'hFFFF)) ? skip_q + 16'd1 : skip_q;
      issued_d = (issue_inc && (issued_q != 16'hFFFF)) ? issued_q + 16'd1 : issued_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tmr_q    <= TMR_RELOAD;
         pend_q   <= '0;
         busy_q   <= '0;
         row_q    <= '0;
         skip_q   <= '0;
         issued_q <= '0;
         sweep_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         row_q    <= row_d;
         skip_q   <= skip_d;
         issued_q <= issued_d;
         sweep_q  <= sweep_d;
      end
   end

   assign wupr_to_refresh = (state_q == S_QUERY);
   assign wupr_clk_enable = (state_q == S_QUERY) || (state_q == S_WAIT);
   assign wupr_ra         = row_q;
   assign ref_req         = (state_q == S_REQ);
   assign ref_row         = row_q;
   assign ref_urgent      = (pend_q == PEND_MAX);
   assign sweep_done      = sweep_q;
   assign skip_cnt        = skip_q;
   assign issued_cnt      = issued_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler: scenario tasks against an
// event-timestamp model of credits, queries, requests and retires.
module tb_refresh_scheduler;

   localparam int RW    = 4;
   localparam int TREFI = 20;
   localparam int TRFC  = 4;
   localparam int MAXP  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wupr_dref = 1'b0;
   logic          ref_grant = 1'b0;
   logic          wupr_to_refresh, wupr_clk_enable, ref_req, ref_urgent, sweep_done;
   logic [RW-1:0] wupr_ra, ref_row;
   logic [15:0]   skip_cnt, issued_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: credits, sweep row, counters, and timestamps of the current transaction.
   int m_pend, m_row, m_skip, m_issued, m_free_at, m_q_cyc, m_end_cyc;
   bit m_engaged, m_req, m_sweep;

   refresh_scheduler #(
      .ROW_WIDTH(RW), .TREFI(TREFI), .TRFC(TRFC), .MAX_POSTPONE(MAXP)
   ) dut (
      .clk(clk), .rst(rst),
      .wupr_to_refresh(wupr_to_refresh), .wupr_ra(wupr_ra),
      .wupr_clk_enable(wupr_clk_enable), .wupr_dref(wupr_dref),
      .ref_req(ref_req), .ref_row(ref_row), .ref_grant(ref_grant),
      .ref_urgent(ref_urgent), .sweep_done(sweep_done),
      .skip_cnt(skip_cnt), .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pend = 0; m_row = 0; m_skip = 0; m_issued = 0;
      m_free_at = 0; m_q_cyc = -10; m_end_cyc = -1;
      m_engaged = 0; m_req = 0; m_sweep = 0;
   endtask

   // Consume the inputs of cycle c; afterwards the model describes cycle c+1.
   task automatic model_advance(input int c, input bit d, input bit g);
      int p_old;
      bit tick, retire, adv;
      p_old  = m_pend;
      tick   = ((c + 1) % TREFI) == 0;
      retire = 0;
      adv    = 0;
      if (m_engaged && c == m_q_cyc + 1) begin
         if (!d) begin
            retire = 1; adv = 1; m_skip++; m_engaged = 0; m_free_at = c + 1;
         end else begin
            m_req = 1;
         end
      end else if (m_req) begin
         if (g) begin
            m_req = 0; m_end_cyc = c + TRFC;
         end
      end else if (m_engaged && c == m_end_cyc) begin
         retire = 1; adv = 1; m_issued++; m_engaged = 0; m_free_at = c + 1;
      end
      if (!m_engaged && c >= m_free_at && p_old != 0) begin
         m_engaged = 1; m_q_cyc = c + 1;
      end
      if (tick && !retire) m_pend = (m_pend < MAXP) ? m_pend + 1 : m_pend;
      else if (retire && !tick) m_pend = m_pend - 1;
      m_sweep = adv && (m_row == (1 << RW) - 1);
      if (adv) m_row = (m_row + 1) % (1 << RW);
   endtask

   function automatic logic [44:0] obs_vec();
      return {wupr_to_refresh, wupr_clk_enable, ref_req, ref_urgent, sweep_done,
              wupr_ra, ref_row & {RW{m_req}}, skip_cnt, issued_cnt};
   endfunction

   function automatic logic [44:0] exp_vec();
      logic q, ce;
      q  = m_engaged && (cyc == m_q_cyc);
      ce = m_engaged && (cyc == m_q_cyc || cyc == m_q_cyc + 1);
      return {q, ce, m_req, (m_pend == MAXP), m_sweep,
              RW'(m_row), RW'(m_req ? m_row : 0), 16'(m_skip), 16'(m_issued)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; wupr_dref = 1'b0; ref_grant = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      if (obs_vec() !== 45'd0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", obs_vec());
      end
      checks++;
      for (int i = 0; i < 25; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (cyc == 21) begin
            if (wupr_to_refresh !== 1'b1 || wupr_ra !== 4'd0) begin
               errors++; $display("FAIL reset_first_query cyc=21 got=%b/%0d exp=1/0", wupr_to_refresh, wupr_ra);
            end
            checks++;
         end
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
   endtask

   task automatic test_skip();
      int nq;
      bit req_seen;
      nq = 0; req_seen = 0;
      do_reset();
      for (int i = 0; i < 105; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL skip_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (wupr_to_refresh === 1'b1) begin
            if (wupr_ra !== RW'(nq)) begin
               errors++; $display("FAIL skip_row q=%0d got=%0d exp=%0d", nq, wupr_ra, nq);
            end
            checks++;
            nq++;
         end
         if (ref_req === 1'b1) req_seen = 1;
         wupr_dref = 1'b0;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (skip_cnt !== 16'd5 || nq != 5 || req_seen) begin
         errors++; $display("FAIL skip_totals got skip=%0d q=%0d req=%0d exp skip=5 q=5 req=0", skip_cnt, nq, req_seen);
      end
      checks++;
   endtask

   task automatic test_refresh();
      int nreq;
      nreq = 0;
      do_reset();
      for (int i = 0; i < 35; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL refresh_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (ref_req === 1'b1) begin
            nreq++;
            if (ref_row !== 4'd0 || cyc != 23) begin
               errors++; $display("FAIL refresh_req cyc=%0d row=%0d exp cyc=23 row=0", cyc, ref_row);
            end
            checks++;
         end
         wupr_dref = 1'b1; ref_grant = 1'b1;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (nreq != 1 || issued_cnt !== 16'd1 || wupr_ra !== 4'd1) begin
         errors++; $display("FAIL refresh_totals got req=%0d issued=%0d row=%0d exp 1/1/1", nreq, issued_cnt, wupr_ra);
      end
      checks++;
   endtask

   task automatic test_postpone();
      int first_urgent, ng;
      int rows[4];
      first_urgent = -1; ng = 0;
      do_reset();
      for (int i = 0; i < 120; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL postpone_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (ref_urgent === 1'b1 && first_urgent < 0) first_urgent = cyc;
         wupr_dref = 1'b1; ref_grant = 1'b0;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (first_urgent != 80 || ref_urgent !== 1'b1 || ref_req !== 1'b1 || ref_row !== 4'd0) begin
         errors++; $display("FAIL postpone_sat got urgent_at=%0d urgent=%b req=%b row=%0d exp 80/1/1/0",
                            first_urgent, ref_urgent, ref_req, ref_row);
      end
      checks++;
      for (int i = 0; i < 80; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL postpone_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (ref_req === 1'b1) begin
            if (ng < 4) rows[ng] = int'(ref_row);
            ng++;
         end
         wupr_dref = 1'b1; ref_grant = 1'b1;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         if (ng < 4 || rows[k] != k) begin
            errors++; $display("FAIL postpone_rows k=%0d got=%0d exp=%0d grants=%0d", k, (ng > k) ? rows[k] : -1, k, ng);
         end
         checks++;
      end
      if (ref_urgent !== 1'b0) begin
         errors++; $display("FAIL postpone_urgent_clear got=%b exp=0", ref_urgent);
      end
      checks++;
   endtask

   task automatic test_sweep();
      int nq, last_row, npulse;
      nq = 0; last_row = -1; npulse = 0;
      do_reset();
      for (int i = 0; i < 344; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sweep_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (sweep_done === 1'b1) begin
            npulse++;
            if (last_row != 15) begin
               errors++; $display("FAIL sweep_pulse_row got=%0d exp=15", last_row);
            end
            checks++;
         end
         if (wupr_to_refresh === 1'b1) begin
            if (nq == 16 && wupr_ra !== 4'd0) begin
               errors++; $display("FAIL sweep_wrap_row got=%0d exp=0", wupr_ra);
            end
            if (nq == 16) checks++;
            last_row = int'(wupr_ra);
            nq++;
         end
         wupr_dref = 1'b0;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (npulse != 1 || nq != 17) begin
         errors++; $display("FAIL sweep_totals got pulses=%0d queries=%0d exp 1/17", npulse, nq);
      end
      checks++;
   endtask

   task automatic test_reset_req();
      do_reset();
      for (int i = 0; i < 30; i++) begin
         wupr_dref = 1'b1; ref_grant = 1'b0;
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (ref_req !== 1'b1) begin
         errors++; $display("FAIL rstreq_pre got req=%b exp=1", ref_req);
      end
      checks++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      if (obs_vec() !== 45'd0) begin
         errors++; $display("FAIL rstreq_cleared got=%h exp=0", obs_vec());
      end
      checks++;
      rst = 1'b0; ref_grant = 1'b1;
      cyc = 0;
      model_reset();
      for (int i = 0; i < 25; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rstreq_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (cyc == 21) begin
            if (wupr_to_refresh !== 1'b1 || wupr_ra !== 4'd0) begin
               errors++; $display("FAIL rstreq_timer got=%b/%0d exp=1/0", wupr_to_refresh, wupr_ra);
            end
            checks++;
         end
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         wupr_dref = 1'($urandom_range(0, 1));
         ref_grant = ($urandom_range(0, 3) == 0);
         model_advance(cyc, wupr_dref, ref_grant);
         step();
      end
      if (skip_cnt + issued_cnt !== 16'(m_skip + m_issued) || m_skip + m_issued < 50) begin
         errors++; $display("FAIL random_totals got=%0d exp=%0d", skip_cnt + issued_cnt, m_skip + m_issued);
      end
      checks++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_skip();
      test_refresh();
      test_postpone();
      test_sweep();
      test_reset_req();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
